// File: rtl/z80_dma_ctrl.sv
// Z80-style single-channel DMA controller: requests the CPU bus, then moves bytes
// src->dst as read/write cycle pairs in bursts of up to BURST_MAX per bus tenure.
module z80_dma_ctrl #(
  parameter int unsigned BURST_MAX = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clken,
  input  logic [15:0] src_addr,
  input  logic [15:0] dst_addr,
  input  logic [15:0] length,
  input  logic        src_io,
  input  logic        dst_io,
  input  logic        src_inc,
  input  logic        dst_inc,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        busrq_n,
  input  logic        busak_n,
  output logic [15:0] addr,
  output logic [7:0]  dq_out,
  input  logic [7:0]  dq_in,
  output logic        dq_oe,
  output logic        mreq_n,
  output logic        iorq_n,
  output logic        rd_n,
  output logic        wr_n,
  input  logic        wait_n
);

  typedef enum logic [3:0] {IDLE, REQ, RD1, RD2, RD3, WR1, WR2, WR3, REL} state_t;

  localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

  state_t      state_q, state_d;
  logic [15:0] src_q, src_d, dst_q, dst_d;
  logic [16:0] rem_q, rem_d;
  logic [7:0]  burst_q, burst_d, data_q, data_d;
  logic        sio_q, sio_d, dio_q, dio_d, sinc_q, sinc_d, dinc_q, dinc_d;
  logic        abort_q, abort_d, finish_q, finish_d, rel_q, rel_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;
  logic        oe_q, oe_d, mreq_q, mreq_d, iorq_q, iorq_d;
  logic        rd_q, rd_d, wr_q, wr_d, busrq_q, busrq_d;

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    rem_d    = rem_q;
    burst_d  = burst_q;
    data_d   = data_q;
    sio_d    = sio_q;
    dio_d    = dio_q;
    sinc_d   = sinc_q;
    dinc_d   = dinc_q;
    finish_d = finish_q;
    rel_d    = rel_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    // abort is remembered on every clk so a pulse between bus ticks is not lost
    abort_d  = abort_q | (abort & busy_q);
    if (clken) begin
      case (state_q)
        IDLE: if (start) begin
          src_d    = src_addr;
          dst_d    = dst_addr;
          rem_d    = (length == 16'd0) ? 17'h10000 : {1'b0, length};
          sio_d    = src_io;
          dio_d    = dst_io;
          sinc_d   = src_inc;
          dinc_d   = dst_inc;
          burst_d  = '0;
          busy_d   = 1'b1;
          abort_d  = 1'b0;
          finish_d = 1'b0;
          state_d  = REQ;
        end
        REQ: if (abort_d) begin
          finish_d = 1'b1;
          rel_d    = 1'b0;
          state_d  = REL;
        end else if (!busak_n) begin
          state_d = RD1;
        end
        RD1: state_d = RD2;
        RD2: if (wait_n) state_d = RD3;
        RD3: begin
          data_d  = dq_in;
          state_d = WR1;
        end
        WR1: state_d = WR2;
        WR2: if (wait_n) state_d = WR3;
        WR3: begin
          if (sinc_q) src_d = src_q + 16'd1;
          if (dinc_q) dst_d = dst_q + 16'd1;
          rem_d   = rem_q - 17'd1;
          burst_d = burst_q + 8'd1;
          rel_d   = 1'b0;
          if (rem_d == '0 || abort_d) begin
            finish_d = 1'b1;
            state_d  = REL;
          end else if (burst_d == BURST_LIM) begin
            state_d = REL;
          end else begin
            state_d = RD1;
          end
        end
        REL: if (rel_q) begin
          if (finish_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            abort_d = 1'b0;
            state_d = IDLE;
          end else begin
            burst_d = '0;
            state_d = REQ;
          end
        end else begin
          rel_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Bus outputs are decoded from the next state and registered, so nothing
  // combinational reaches the pins.
  always_comb begin
    addr_d  = '0;
    dout_d  = '0;
    oe_d    = 1'b0;
    mreq_d  = 1'b1;
    iorq_d  = 1'b1;
    rd_d    = 1'b1;
    wr_d    = 1'b1;
    busrq_d = 1'b1;
    case (state_d)
      REQ: busrq_d = 1'b0;
      RD1, RD2: begin
        busrq_d = 1'b0;
        addr_d  = src_d;
        mreq_d  = sio_d;
        iorq_d  = ~sio_d;
        rd_d    = 1'b0;
      end
      RD3: begin
        busrq_d = 1'b0;
        addr_d  = src_d;
      end
      WR1, WR2: begin
        busrq_d = 1'b0;
        addr_d  = dst_d;
        dout_d  = data_d;
        oe_d    = 1'b1;
        mreq_d  = dio_d;
        iorq_d  = ~dio_d;
        wr_d    = (state_d != WR2);
      end
      WR3: begin
        busrq_d = 1'b0;
        addr_d  = dst_d;
        dout_d  = data_d;
        oe_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      rem_q    <= '0;
      burst_q  <= '0;
      data_q   <= '0;
      sio_q    <= 1'b0;
      dio_q    <= 1'b0;
      sinc_q   <= 1'b0;
      dinc_q   <= 1'b0;
      abort_q  <= 1'b0;
      finish_q <= 1'b0;
      rel_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
      oe_q     <= 1'b0;
      mreq_q   <= 1'b1;
      iorq_q   <= 1'b1;
      rd_q     <= 1'b1;
      wr_q     <= 1'b1;
      busrq_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      rem_q    <= rem_d;
      burst_q  <= burst_d;
      data_q   <= data_d;
      sio_q    <= sio_d;
      dio_q    <= dio_d;
      sinc_q   <= sinc_d;
      dinc_q   <= dinc_d;
      abort_q  <= abort_d;
      finish_q <= finish_d;
      rel_q    <= rel_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      oe_q     <= oe_d;
      mreq_q   <= mreq_d;
      iorq_q   <= iorq_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      busrq_q  <= busrq_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign busrq_n = busrq_q;
  assign addr    = addr_q;
  assign dq_out  = dout_q;
  assign dq_oe   = oe_q;
  assign mreq_n  = mreq_q;
  assign iorq_n  = iorq_q;
  assign rd_n    = rd_q;
  assign wr_n    = wr_q;

endmodule

// File: tb/tb_z80_dma_ctrl.sv
// Scoreboard bench for z80_dma_ctrl: a transfer-level model queues expected byte moves
// and bus tenures; a negedge monitor pops and compares as the DUT performs them.
module tb_z80_dma_ctrl;

  localparam int unsigned BM = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clken = 1'b1;
  logic [15:0] src_addr = '0, dst_addr = '0, length = '0;
  logic        src_io = 1'b0, dst_io = 1'b0, src_inc = 1'b1, dst_inc = 1'b1;
  logic        start = 1'b0, abort = 1'b0;
  logic        busy, done, busrq_n, busak_n;
  logic [15:0] addr;
  logic [7:0]  dq_out, dq_in;
  logic        dq_oe, mreq_n, iorq_n, rd_n, wr_n;
  logic        wait_n = 1'b1;
  logic [7:0]  salt = 8'h3C;

  typedef struct packed {
    logic [15:0] s;
    logic        sio;
    logic [15:0] d;
    logic        dio;
    logic [7:0]  data;
  } xfer_t;

  typedef struct packed {
    logic [16:0] n;
    logic        last;
  } tenure_t;

  xfer_t   exp_q[$];
  tenure_t ten_q[$];

  int n_checks = 0, n_fail = 0;
  int done_count = 0, exp_done = 0, read_count = 0;
  int wait_cfg = 0;
  bit timing_on = 1'b1, clk_rand = 1'b0, force_ck = 1'b0;

  function automatic logic [7:0] mem_fn(input logic [15:0] a, input logic [7:0] s);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ s;
  endfunction

  assign busak_n = busrq_n;
  assign dq_in   = mem_fn(addr, salt);

  z80_dma_ctrl #(.BURST_MAX(BM)) dut (
    .clk(clk), .reset(reset), .clken(clken),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .src_io(src_io), .dst_io(dst_io), .src_inc(src_inc), .dst_inc(dst_inc),
    .start(start), .abort(abort), .busy(busy), .done(done),
    .busrq_n(busrq_n), .busak_n(busak_n), .addr(addr), .dq_out(dq_out),
    .dq_in(dq_in), .dq_oe(dq_oe), .mreq_n(mreq_n), .iorq_n(iorq_n),
    .rd_n(rd_n), .wr_n(wr_n), .wait_n(wait_n)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    clken = (clk_rand && !force_ck) ? ($urandom_range(0, 3) != 0) : 1'b1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: also plays the wait_n-inserting slave device.
  logic        prev_rd_n = 1'b1, prev_wr_n = 1'b1, prev_wstr = 1'b0, prev_busrq = 1'b1;
  logic [15:0] rd_addr = '0;
  logic        rd_io = 1'b0, rd_mreq = 1'b0, wstr;
  int          rd_len = 0, wr_len = 0, wcnt = 0, tenure_bytes = 0, gap = 0;
  bit          cont = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      prev_rd_n = 1'b1; prev_wr_n = 1'b1; prev_wstr = 1'b0; prev_busrq = 1'b1;
      cont = 1'b0; wcnt = 0; wait_n = 1'b1; tenure_bytes = 0;
    end else begin
      if (wcnt > 0) begin
        wcnt--;
        if (wcnt == 0) wait_n = 1'b1;
      end
      if (done) done_count++;

      if (!rd_n) begin
        if (prev_rd_n) begin
          rd_addr = addr; rd_io = !iorq_n; rd_mreq = !mreq_n;
          read_count++; rd_len = 1;
          if (wait_cfg > 0) begin wait_n = 1'b0; wcnt = wait_cfg + 1; end
        end else rd_len++;
      end else if (!prev_rd_n && timing_on) begin
        check("rd_strobe_ticks", 32'(rd_len), 32'(wait_cfg + 2));
      end

      wstr = dq_oe && (!mreq_n || !iorq_n);
      if (wstr && !prev_wstr) begin
        tenure_bytes++;
        if (wait_cfg > 0) begin wait_n = 1'b0; wcnt = wait_cfg + 1; end
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_write: got write to 0x%0h, expected none", addr);
        end else begin
          xfer_t e;
          e = exp_q.pop_front();
          check("rd_addr", 32'(rd_addr), 32'(e.s));
          check("rd_space", {30'd0, rd_io, rd_mreq}, {30'd0, e.sio, ~e.sio});
          check("wr_addr", 32'(addr), 32'(e.d));
          check("wr_space", {30'd0, !iorq_n, !mreq_n}, {30'd0, e.dio, ~e.dio});
          check("wr_data", 32'(dq_out), 32'(e.data));
        end
      end

      if (!wr_n) begin
        if (prev_wr_n) wr_len = 1; else wr_len++;
      end else if (!prev_wr_n && timing_on) begin
        check("wr_strobe_ticks", 32'(wr_len), 32'(wait_cfg + 1));
      end

      if (busrq_n && !prev_busrq) begin
        check("rel_bus_idle", {11'd0, addr, dq_oe, mreq_n, iorq_n, rd_n, wr_n},
              {11'd0, 16'h0000, 1'b0, 4'hF});
        if (ten_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_tenure: got tenure of %0d bytes, expected none", tenure_bytes);
        end else begin
          tenure_t t;
          t = ten_q.pop_front();
          check("tenure_bytes", 32'(tenure_bytes), 32'(t.n));
          cont = !t.last;
        end
        gap = 1;
      end else if (busrq_n) begin
        gap++;
      end
      if (!busrq_n && prev_busrq) begin
        if (cont && timing_on) check("rel_gap_ticks", 32'(gap), 32'd2);
        cont = 1'b0;
        tenure_bytes = 0;
      end

      prev_rd_n = rd_n; prev_wr_n = wr_n; prev_wstr = wstr; prev_busrq = busrq_n;
    end
  end

  task automatic load_model(input logic [15:0] s, input logic [15:0] d, input int n,
                            input logic sio, input logic dio, input logic si, input logic di);
    logic [15:0] a_s, a_d;
    int rem, c;
    xfer_t e;
    tenure_t t;
    a_s = s; a_d = d;
    for (int i = 0; i < n; i++) begin
      e = '{s: a_s, sio: sio, d: a_d, dio: dio, data: mem_fn(a_s, salt)};
      exp_q.push_back(e);
      if (si) a_s = a_s + 16'd1;
      if (di) a_d = a_d + 16'd1;
    end
    rem = n;
    while (rem > 0) begin
      c = (rem > int'(BM)) ? int'(BM) : rem;
      rem -= c;
      t = '{n: 17'(c), last: (rem == 0)};
      ten_q.push_back(t);
    end
  endtask

  task automatic issue_start(input logic [15:0] s, input logic [15:0] d, input logic [15:0] len,
                             input logic sio, input logic dio, input logic si, input logic di);
    force_ck = 1'b1;
    @(negedge clk);
    src_addr = s; dst_addr = d; length = len;
    src_io = sio; dst_io = dio; src_inc = si; dst_inc = di;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_xfer(input logic [15:0] s, input logic [15:0] d, input logic [15:0] len,
                          input logic sio, input logic dio, input logic si, input logic di,
                          input int abort_at, input bit restart);
    int n, base_rd, cyc;
    n = (abort_at > 0) ? abort_at : int'(len);
    load_model(s, d, n, sio, dio, si, di);
    exp_done++;
    base_rd = read_count;
    issue_start(s, d, len, sio, dio, si, di);
    if (restart) begin
      src_addr = ~s; dst_addr = ~d; length = 16'd7; src_inc = ~si; start = 1'b1;
    end
    #1 check("busy_after_start", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    force_ck = 1'b0;
    if (abort_at > 0) begin
      cyc = 0;
      while (read_count < base_rd + abort_at && cyc < 500) begin
        @(negedge clk); #1; cyc++;
      end
      check("abort_read_reached", 32'(read_count), 32'(base_rd + abort_at));
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    cyc = 0;
    while (done_count != exp_done && cyc < 3000) begin
      @(negedge clk); #1; cyc++;
    end
    check("done_seen", 32'(done_count), 32'(exp_done));
    repeat (3) @(negedge clk);
    #1;
    check("done_single", 32'(done_count), 32'(exp_done));
    check("busy_clear", 32'(busy), 32'd0);
    check("busrq_released", 32'(busrq_n), 32'd1);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("tenures_drained", 32'(ten_q.size()), 32'd0);
  endtask

  initial begin
    int cyc;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busrq", 32'(busrq_n), 32'd1);
    check("rst_bus", {11'd0, addr, dq_oe, mreq_n, iorq_n, rd_n, wr_n}, {11'd0, 16'h0000, 1'b0, 4'hF});
    #1 reset = 1'b0;

    // basic transfer, with a second start while busy that must be ignored
    run_xfer(16'h1000, 16'h2000, 16'd3, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b1);
    // three tenures 16/16/8
    salt = 8'h5A;
    run_xfer(16'h4000, 16'h8000, 16'd40, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    // held IO source, destination wraps past 0xFFFF
    run_xfer(16'h00F0, 16'hFFFF, 16'd2, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    // wait states on every strobe
    wait_cfg = 3;
    run_xfer(16'h3000, 16'h0010, 16'd2, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    wait_cfg = 0;
    // abort during the 2nd byte's read
    run_xfer(16'h1234, 16'h5678, 16'd10, 1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b0);

    // reset during a write strobe
    load_model(16'h0100, 16'h0200, 5, 1'b0, 1'b0, 1'b1, 1'b1);
    issue_start(16'h0100, 16'h0200, 16'd5, 1'b0, 1'b0, 1'b1, 1'b1);
    force_ck = 1'b0;
    cyc = 0;
    while (wr_n && cyc < 200) begin
      @(negedge clk); #1; cyc++;
    end
    check("wr2_reached", 32'(wr_n), 32'd0);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_bus", {11'd0, addr, dq_oe, mreq_n, iorq_n, rd_n, wr_n}, {11'd0, 16'h0000, 1'b0, 4'hF});
    check("rst_mid_busrq", 32'(busrq_n), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    ten_q.delete();
    #2 reset = 1'b0;
    repeat (5) @(negedge clk);
    #1 check("rst_no_done", 32'(done_count), 32'(exp_done));
    run_xfer(16'hA000, 16'hB000, 16'd4, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);

    // randomized transfers: odd runs throttle clken, even runs add wait states
    for (int t = 0; t < 8; t++) begin
      clk_rand  = (t % 2) == 1;
      timing_on = !clk_rand;
      wait_cfg  = clk_rand ? 0 : int'($urandom_range(0, 2));
      salt      = 8'($urandom);
      run_xfer(16'($urandom), 16'($urandom), 16'($urandom_range(1, 40)),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0, 1'b0);
    end
    clk_rand = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/z80_dma_ctrl.md
Z80_DMA_CTRL -- requirements
Module: z80_dma_ctrl

Interface
REQ-001 SHALL have parameter BURST_MAX, default 16: bytes moved per bus tenure before releasing the bus; legal range 1..255.
REQ-002 SHALL have ports: clk in 1, system clock; reset in 1, asynchronous active-high reset.
REQ-003 SHALL have port clken in 1: bus-tick enable; all FSM/counter updates occur only on clk edges with clken=1.
REQ-004 SHALL have ports src_addr in 16, dst_addr in 16, length in 16: transfer setup, sampled on start; length 0 means 65536.
REQ-005 SHALL have ports src_io in 1, dst_io in 1, src_inc in 1, dst_inc in 1: per side, IORQ instead of MREQ, and increment (1) or hold (0) the address.
REQ-006 SHALL have ports start in 1 (pulse) and abort in 1 (pulse).
REQ-007 SHALL have ports busy out 1 and done out 1 (one-clk pulse).
REQ-008 SHALL have ports busrq_n out 1 and busak_n in 1 (CPU bus handshake).
REQ-009 SHALL have ports addr out 16, dq_out out 8, dq_in in 8, dq_oe out 1, mreq_n out 1, iorq_n out 1, rd_n out 1, wr_n out 1, wait_n in 1: bus master signals, valid only while owning the bus.

Function
REQ-010 SHALL implement FSM states IDLE, REQ, RD1, RD2, RD3, WR1, WR2, WR3, REL; each transition requires clken=1.
REQ-011 IDLE: start=1 SHALL latch setup registers, clear burst counter, set busy=1, and go to REQ; start while busy SHALL be ignored.
REQ-012 REQ: SHALL drive busrq_n=0; on busak_n=0 sampled, SHALL go to RD1.
REQ-013 RD1: addr=src, mreq_n or iorq_n (per src_io) =0, rd_n=0.
REQ-014 RD2: strobes held; stay while wait_n=0; go to RD3 when wait_n=1.
REQ-015 RD3: SHALL latch dq_in into the data register and deassert all strobes; go to WR1.
REQ-016 WR1: addr=dst, dq_out=data register, dq_oe=1, mreq_n or iorq_n (per dst_io) =0, wr_n=1.
REQ-017 WR2: wr_n=0; stay while wait_n=0; go to WR3 when wait_n=1.
REQ-018 WR3: wr_n, mreq_n and iorq_n SHALL be 1 while dq_oe=1 holds data; SHALL apply the address update, decrement the remaining count, and increment the burst counter.
REQ-019 Address update SHALL be 16-bit modulo: 0xFFFF+1=0x0000; a held side is unchanged.
REQ-020 Leaving WR3: if remaining=0 or abort is pending, go to REL with finish flag set; else if burst count=BURST_MAX, go to REL; else go to RD1, keeping the bus.
REQ-021 REL: busrq_n=1 and all strobes inactive for exactly 2 clken ticks; then go to IDLE if the finish flag is set, else to REQ with the burst counter cleared.
REQ-022 Entering IDLE from REL with finish SHALL pulse done=1 for one clk and set busy=0.
REQ-023 abort SHALL be latched as pending; in REQ before busak_n=0 it SHALL go directly to REL with finish; otherwise the current byte completes first (REQ-020).
REQ-024 abort and start in the same cycle while IDLE: start wins and abort is ignored.
REQ-025 Outside RD1..WR3, addr=0, dq_oe=0, and mreq_n, iorq_n, rd_n and wr_n SHALL be 1.
REQ-026 All bus outputs SHALL be registered (no combinational path from inputs).
REQ-027 If busak_n goes 1 while in RD1..WR3 (protocol error), the block SHALL finish the byte regardless.

Reset
REQ-028 reset=1 SHALL force IDLE asynchronously: busy=0, done=0, busrq_n=1, dq_oe=0, addr=0, all strobes 1, counters, pending abort and data register 0.
REQ-029 Reset mid-transfer SHALL abandon the transfer without a done pulse.

Verification
REQ-030 Scenario 1: src=0x1000, dst=0x2000, length=3, inc both, clken always 1, busak_n follows busrq_n -> 3 read/write pairs at 0x1000->0x2000..0x1002->0x2002; done pulses once; busrq_n=1 after.
REQ-031 Scenario 2: length=40, BURST_MAX=16 -> three bus tenures of 16, 16 and 8 bytes, each separated by 2 ticks of busrq_n=1.
REQ-032 Scenario 3: src=0x00F0 with src_io=1 and src_inc=0, dst=0xFFFF, length=2 -> both reads use iorq_n at 0x00F0; writes go to 0xFFFF then 0x0000.
REQ-033 Scenario 4: wait_n=0 for 3 ticks during RD2 and WR2 -> the state holds 3 extra ticks; data is unchanged.
REQ-034 Scenario 5: abort during the 2nd byte's RD2 with length=10 -> the 2nd byte completes, then REL and done; exactly 2 writes occur.
REQ-035 Scenario 6: reset asserted in WR2 -> all bus outputs go inactive in the same cycle; no done pulse; a following start works normally.
